stream_mux_2x1: RTL and testbench

STREAM_MUX_2X1 -- requirements
Module: stream_mux_2x1

---
 rtl/stream_mux_pkg.sv | 26 ++
 rtl/rr_arb_2.sv | 21 ++
 rtl/stream_mux_2x1.sv | 131 +++++++++++++
 tb/tb_stream_mux_2x1.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types for the 2:1 stream mux: lock FSM states, default width, round-robin pick.
// Packet lock is enabled by defining STREAM_MUX_PKT_LOCK_EN.
package stream_mux_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } lock_state_t;

   // A lone requester always wins; on a tie the source not served last time wins.
   function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
      logic pick;
      pick = 1'b0;
      case (req)
         2'b01:   pick = 1'b0;
         2'b10:   pick = 1'b1;
         2'b11:   pick = ~last_grant;
         default: pick = 1'b0;
      endcase
      return pick;
   endfunction

endpackage

// File: rtl/rr_arb_2.sv
// Two-way round-robin grant selection with packet lock override; purely combinational.
// No backpressure of its own: the caller qualifies the grant with its load condition.
module rr_arb_2
   import stream_mux_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic [1:0] lock_state,
   output logic       grant
);

   always_comb begin
      grant = 1'b0;
      case (lock_state)
         LOCK0:   grant = 1'b0;
         LOCK1:   grant = 1'b1;
         default: grant = rr_pick(req, last_grant);
      endcase
   end

endmodule

// File: rtl/stream_mux_2x1.sv
// 2:1 valid/ready stream merge, round-robin, registered output (1 cycle latency); a stalled
// output beat drops both input readies. STREAM_MUX_PKT_LOCK_EN adds last ports and packet lock.
module stream_mux_2x1
   import stream_mux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in0_data,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic [WIDTH-1:0] in1_data,
   input  logic             in1_valid,
   output logic             in1_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sel,
   output logic             out_valid,
   input  logic             out_ready
`ifdef STREAM_MUX_PKT_LOCK_EN
   ,
   input  logic             in0_last,
   input  logic             in1_last,
   output logic             out_last
`endif
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_sel_q, out_sel_d;
   logic             last_grant_q, last_grant_d;

   logic             load;
   logic             grant;
   logic             accept;
   logic [1:0]       lock_vec;

`ifdef STREAM_MUX_PKT_LOCK_EN
   lock_state_t      state_q, state_d;
   logic             out_last_q, out_last_d;
   logic             sel_last;

   assign lock_vec = state_q;
   assign sel_last = grant ? in1_last : in0_last;
   assign out_last = out_last_q;
`else
   assign lock_vec = ARB;
`endif

   rr_arb_2 u_arb (
      .req        ({in1_valid, in0_valid}),
      .last_grant (last_grant_q),
      .lock_state (lock_vec),
      .grant      (grant)
   );

   assign load   = ~out_valid_q | out_ready;
   assign accept = load & (grant ? in1_valid : in0_valid);

   // Readies are gated by rst_n so nothing is handshaken while reset is held.
   assign in0_ready = rst_n & load & ~grant;
   assign in1_ready = rst_n & load & grant;

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_sel_d    = out_sel_q;
      last_grant_d = last_grant_q;
      if (accept) begin
         out_valid_d  = 1'b1;
         out_data_d   = grant ? in1_data : in0_data;
         out_sel_d    = grant;
         last_grant_d = grant;
      end else if (out_ready) begin
         out_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_sel_q    <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_sel_q    <= out_sel_d;
         last_grant_q <= last_grant_d;
      end
   end

`ifdef STREAM_MUX_PKT_LOCK_EN
   // A source holds the output from its first non-last beat until its last beat is taken.
   always_comb begin
      state_d    = state_q;
      out_last_d = out_last_q;
      if (accept) begin
         out_last_d = sel_last;
      end
      case (state_q)
         ARB: begin
            if (accept && !sel_last) begin
               state_d = grant ? LOCK1 : LOCK0;
            end
         end
         LOCK0, LOCK1: begin
            if (accept && sel_last) begin
               state_d = ARB;
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_last_q <= out_last_d;
      end
   end
`endif

endmodule

// File: tb/tb_stream_mux_2x1.sv
// Self-checking bench for stream_mux_2x1: vector table, hand-written corner sequences,
// and a randomized run against a queue-based scoreboard.
module tb_stream_mux_2x1;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] in0_data, in1_data, out_data;
   logic         in0_valid, in1_valid, in0_ready, in1_ready;
   logic         out_sel, out_valid, out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
   logic         in0_last, in1_last, out_last;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   stream_mux_2x1 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_data  (in0_data),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in1_data  (in1_data),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef STREAM_MUX_PKT_LOCK_EN
      ,
      .in0_last  (in0_last),
      .in1_last  (in1_last),
      .out_last  (out_last)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Single-beat packets everywhere except the dedicated lock sequence.
   task automatic drive(input logic v0, input logic [W-1:0] d0, input logic v1,
                        input logic [W-1:0] d1, input logic ordy);
      in0_valid = v0;
      in0_data  = d0;
      in1_valid = v1;
      in1_data  = d1;
      out_ready = ordy;
`ifdef STREAM_MUX_PKT_LOCK_EN
      in0_last  = 1'b1;
      in1_last  = 1'b1;
`endif
   endtask

   task automatic reset_dut();
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic         v0;
      logic [W-1:0] d0;
      logic         v1;
      logic [W-1:0] d1;
      logic         ordy;
      logic         chk_rdy;
      logic         r0;
      logic         r1;
      logic         ov;
      logic [W-1:0] od;
      logic         os;
   } vec_t;

   localparam int NVEC = 15;
   vec_t tbl [NVEC];

   logic [8:0] sb_q [$];
   logic [8:0] exp_beat;

   initial begin
      // Vector table: inputs for one cycle, readies expected during it, outputs after the edge.
      tbl[0]  = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1};
      tbl[1]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
      tbl[2]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
      tbl[3]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
      tbl[4]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
      tbl[5]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
      tbl[6]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
      tbl[7]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[10] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0};
      tbl[11] = '{1'b1, 8'h44, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0};
      tbl[12] = '{1'b1, 8'h44, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1};
      tbl[13] = '{1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0};
      tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

      // Reset held from time 0 with a source offering data.
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_data", 32'(out_data), 32'd0);
      check("reset out_sel", 32'(out_sel), 32'd0);
      check("reset in0_ready", 32'(in0_ready), 32'd0);
      check("reset in1_ready", 32'(in1_ready), 32'd0);

      reset_dut();
      for (int i = 0; i < NVEC; i++) begin
         drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].ordy);
         #1;
         if (tbl[i].chk_rdy) begin
            check($sformatf("vec%0d in0_ready", i), 32'(in0_ready), 32'(tbl[i].r0));
            check($sformatf("vec%0d in1_ready", i), 32'(in1_ready), 32'(tbl[i].r1));
         end
         @(posedge clk);
         #1;
         check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
         if (tbl[i].ov) begin
            check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(tbl[i].od));
            check($sformatf("vec%0d out_sel", i), 32'(out_sel), 32'(tbl[i].os));
         end
      end

      // Reset asserted between edges while an in1 beat is stalled on the output.
      reset_dut();
      drive(1'b0, 8'h00, 1'b1, 8'h22, 1'b1);
      @(posedge clk);
      #1;
      drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
      check("mid pre-reset out_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid reset out_valid", 32'(out_valid), 32'd0);
      check("mid reset out_data", 32'(out_data), 32'd0);
      check("mid reset out_sel", 32'(out_sel), 32'd0);
      check("mid reset in0_ready", 32'(in0_ready), 32'd0);
      check("mid reset in1_ready", 32'(in1_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      check("post reset tie in0_ready", 32'(in0_ready), 32'd1);
      check("post reset tie in1_ready", 32'(in1_ready), 32'd0);
      @(posedge clk);
      #1;
      check("post reset first beat data", 32'(out_data), 32'h11);
      check("post reset first beat sel", 32'(out_sel), 32'd0);

      // in0 offers a 3-beat packet while in1 is valid throughout.
      begin
         logic [W-1:0] got_d [4];
         logic         got_s [4];
         logic [W-1:0] exp_d [4];
         logic         exp_s [4];
         int p0, p1, n;
         logic a0, a1;
`ifdef STREAM_MUX_PKT_LOCK_EN
         logic got_l [4];
         logic exp_l [4];
         exp_d = '{8'h01, 8'h02, 8'h03, 8'h80};
         exp_s = '{1'b0, 1'b0, 1'b0, 1'b1};
         exp_l = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
         exp_d = '{8'h01, 8'h80, 8'h02, 8'h81};
         exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
         reset_dut();
         p0 = 0;
         p1 = 0;
         n  = 0;
         for (int cyc = 0; cyc < 12 && n < 4; cyc++) begin
            drive(p0 < 3, 8'(p0 + 1), 1'b1, 8'(8'h80 + p1), 1'b1);
`ifdef STREAM_MUX_PKT_LOCK_EN
            in0_last = (p0 == 2);
`endif
            #1;
            a0 = in0_valid & in0_ready;
            a1 = in1_valid & in1_ready;
            @(posedge clk);
            #1;
            if (a0) p0++;
            if (a1) p1++;
            if (out_valid) begin
               got_d[n] = out_data;
               got_s[n] = out_sel;
`ifdef STREAM_MUX_PKT_LOCK_EN
               got_l[n] = out_last;
`endif
               n++;
            end
         end
         check("pkt seq beat count", 32'(n), 32'd4);
         for (int k = 0; k < n; k++) begin
            check($sformatf("pkt beat%0d data", k), 32'(got_d[k]), 32'(exp_d[k]));
            check($sformatf("pkt beat%0d sel", k), 32'(got_s[k]), 32'(exp_s[k]));
`ifdef STREAM_MUX_PKT_LOCK_EN
            check($sformatf("pkt beat%0d last", k), 32'(got_l[k]), 32'(exp_l[k]));
`endif
         end
      end

      // Random traffic against a scoreboard: beats leave in acceptance order, tie
      // winner alternates, stalled output stays stable, nothing lost or duplicated.
      begin
         int sent, got;
         logic acc0, acc1, last_win, win, prev_hold, prev_s, load_m;
         logic [W-1:0] prev_d;
         reset_dut();
         sb_q.delete();
         sent = 0;
         got = 0;
         acc0 = 1'b0;
         acc1 = 1'b0;
         last_win = 1'b1;
         prev_hold = 1'b0;
         prev_d = '0;
         prev_s = 1'b0;
         for (int cyc = 0; cyc < 400; cyc++) begin
            if (!in0_valid || acc0) begin
               in0_valid = ($urandom_range(0, 2) != 0) && (cyc < 380);
               in0_data  = 8'($urandom);
            end
            if (!in1_valid || acc1) begin
               in1_valid = ($urandom_range(0, 2) != 0) && (cyc < 380);
               in1_data  = 8'($urandom);
            end
            out_ready = (cyc >= 380) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            check("rand out_valid vs pending", 32'(out_valid), 32'(sb_q.size() != 0));
            if (prev_hold) begin
               check("rand held data", 32'(out_data), 32'(prev_d));
               check("rand held sel", 32'(out_sel), 32'(prev_s));
            end
            if (out_valid && out_ready) begin
               if (sb_q.size() > 0) begin
                  exp_beat = sb_q.pop_front();
                  check("rand out_data", 32'(out_data), 32'(exp_beat[7:0]));
                  check("rand out_sel", 32'(out_sel), 32'(exp_beat[8]));
                  got++;
               end
            end
            load_m = !out_valid || out_ready;
            if (!load_m) begin
               check("rand readies under stall", 32'({in1_ready, in0_ready}), 32'd0);
            end else if (in0_valid || in1_valid) begin
               win = (in0_valid && in1_valid) ? ~last_win : in1_valid;
               check("rand grant readies", 32'({in1_ready, in0_ready}),
                     win ? 32'd2 : 32'd1);
            end
            acc0 = in0_valid & in0_ready;
            acc1 = in1_valid & in1_ready;
            if (acc0) begin
               sb_q.push_back({1'b0, in0_data});
               sent++;
               last_win = 1'b0;
            end
            if (acc1) begin
               sb_q.push_back({1'b1, in1_data});
               sent++;
               last_win = 1'b1;
            end
            prev_hold = out_valid && !out_ready;
            prev_d = out_data;
            prev_s = out_sel;
            @(posedge clk);
            #1;
         end
         check("rand beats delivered", 32'(got), 32'(sent));
         check("rand final out_valid", 32'(out_valid), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
